// File: rtl/wb_arbiter_pkg.sv
// Shared core definitions for the writeback arbiter: register/data widths,
// default sizing and the MDU result buffer entry type.
`ifndef RF_RANGE
`define RF_RANGE 4:0
`endif
`ifndef DATA_RANGE
`define DATA_RANGE 31:0
`endif

package wb_arbiter_pkg;

    localparam int STARVE_MAX_DEFAULT = 4;
    localparam int FIFO_DEPTH_DEFAULT = 2;

    typedef struct packed {
        logic [`RF_RANGE]   regid;
        logic [`DATA_RANGE] data;
    } wb_mdu_entry_t;

endpackage

// File: rtl/wb_arbiter_fifo.sv
// Synchronous FIFO holding MDU results; the head is read combinationally so
// the arbiter can grant it in the same cycle it becomes visible.
module wb_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    T           r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_do_push;
    logic        w_do_pop;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign dout      = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write port arbiter between the pipeline WB stage and buffered
// MDU results, with starvation-forced stalls and an MDU busy scoreboard.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_flush,
    input  logic        pipe_reg_write,
    input  logic [4:0]  pipe_reg_regid,
    input  logic [31:0] pipe_reg_writedata,
    input  logic        mdu_issue,
    input  logic [4:0]  mdu_issue_regid,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_regid,
    input  logic [31:0] mdu_writedata,
    output logic        wb_stall,
    output logic        rf_write,
    output logic [4:0]  rf_regid,
    output logic [31:0] rf_writedata,
    output logic [31:0] busy_mask
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    wb_mdu_entry_t w_push_entry;
    wb_mdu_entry_t w_head;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic          w_fifo_nonempty;
    logic          w_push;
    logic          w_pipe_req;
    logic          w_starved;
    logic          w_grant_fifo;
    logic          w_grant_pipe;
    logic [SW-1:0] r_starve_cnt;
    logic [31:1]   r_busy;
    logic [31:1]   w_busy_next;

    assign w_push_entry    = '{regid: mdu_regid, data: mdu_writedata};
    assign mdu_ready       = ~w_fifo_full;
    assign w_push          = mdu_valid & ~w_fifo_full;
    assign w_fifo_nonempty = ~w_fifo_empty;
    assign w_pipe_req      = pipe_reg_write & ~wb_flush & (pipe_reg_regid != 5'd0);
    assign w_starved       = (r_starve_cnt == SW'(STARVE_MAX));

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (wb_mdu_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (w_push_entry),
        .pop   (w_grant_fifo),
        .dout  (w_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // Grants are blocked during reset so a discarded entry never reaches the RF.
    always_comb begin
        w_grant_fifo = 1'b0;
        w_grant_pipe = 1'b0;
        wb_stall     = 1'b0;
        rf_write     = 1'b0;
        rf_regid     = '0;
        rf_writedata = '0;
        if (!rst) begin
            if (w_fifo_nonempty && w_starved) begin
                w_grant_fifo = 1'b1;
                wb_stall     = 1'b1;
            end else if (w_pipe_req) begin
                w_grant_pipe = 1'b1;
            end else if (w_fifo_nonempty) begin
                w_grant_fifo = 1'b1;
            end
        end
        if (w_grant_pipe) begin
            rf_write     = 1'b1;
            rf_regid     = pipe_reg_regid;
            rf_writedata = pipe_reg_writedata;
        end else if (w_grant_fifo) begin
            rf_write     = (w_head.regid != 5'd0);
            rf_regid     = w_head.regid;
            rf_writedata = w_head.data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (!w_fifo_nonempty || w_grant_fifo) begin
            r_starve_cnt <= '0;
        end else if (!w_starved) begin
            r_starve_cnt <= r_starve_cnt + SW'(1);
        end
    end

    // A new issue to a register overrides the retirement of an older result.
    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_busy
            assign w_busy_next[gi] =
                (mdu_issue && (mdu_issue_regid == 5'(gi))) ? 1'b1 :
                (w_grant_fifo && (w_head.regid == 5'(gi))) ? 1'b0 :
                r_busy[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign busy_mask = {r_busy, 1'b0};

endmodule
